// File: rtl/pwm_dac.sv
// 8-bit PWM audio DAC with a one-deep sample holding register.
// Duty is swapped in from the holding register only at frame boundaries.
module pwm_dac #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic       pwm_out,
  output logic       frame_start,
  output logic       underrun
);

  localparam logic [9:0] PreMax = 10'(PRESCALE - 1);

  logic [9:0] r_pre;
  logic [7:0] r_cnt;
  logic [7:0] r_duty;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic       r_en_q;
  logic       r_frame_start;
  logic       r_underrun;

  logic       w_tick;
  logic       w_boundary;
  logic       w_accept;
  logic       w_en_rise;
  logic [9:0] w_pre_d;
  logic [7:0] w_cnt_d;

  assign w_tick     = enable && (r_pre == PreMax);
  assign w_boundary = w_tick && (r_cnt == 8'hFF);
  assign w_accept   = sample_valid && !r_hold_full;
  assign w_en_rise  = enable && !r_en_q;

  always_comb begin
    w_pre_d = r_pre;
    w_cnt_d = r_cnt;
    if (!enable) begin
      w_pre_d = '0;
      w_cnt_d = '0;
    end else if (w_tick) begin
      w_pre_d = '0;
      w_cnt_d = r_cnt + 8'd1;
    end else begin
      w_pre_d = r_pre + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_pre         <= '0;
      r_cnt         <= '0;
      r_duty        <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_en_q        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_pre         <= w_pre_d;
      r_cnt         <= w_cnt_d;
      r_en_q        <= enable;
      r_frame_start <= w_boundary || w_en_rise;
      r_underrun    <= w_boundary && !r_hold_full;
      if (w_boundary && r_hold_full) begin
        r_duty <= r_hold;
      end
      // An accept can only happen with hold empty, so it never races the duty swap.
      if (w_accept) begin
        r_hold      <= sample;
        r_hold_full <= 1'b1;
      end else if (w_boundary) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign sample_ready = !r_hold_full;
  assign pwm_out      = enable && (r_cnt < r_duty);
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: cycle scoreboard plus per-phase aggregate checks,
// and a PRESCALE=3 instance for the long-frame corner case.
module tb_pwm_dac;

  localparam int P = 1;

  logic       clk = 1'b0;
  logic       nRst = 1'b1;
  logic       enable = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       sample_ready, pwm_out, frame_start, underrun;

  logic       en3 = 1'b0;
  logic       v3 = 1'b0;
  logic [7:0] s3 = 8'h00;
  logic       rdy3, pwm3, fs3, ur3;

  always #5 clk = ~clk;

  pwm_dac #(.PRESCALE(1)) dut (
    .clk          (clk),
    .nRst         (nRst),
    .enable       (enable),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  pwm_dac #(.PRESCALE(3)) dut3 (
    .clk          (clk),
    .nRst         (nRst),
    .enable       (en3),
    .sample       (s3),
    .sample_valid (v3),
    .sample_ready (rdy3),
    .pwm_out      (pwm3),
    .frame_start  (fs3),
    .underrun     (ur3)
  );

  typedef struct packed {
    logic rdy;
    logic pwm;
    logic fs;
    logic ur;
  } obs_t;

  typedef struct {
    string      name;
    logic       en;
    logic       vld;
    logic [7:0] smp;
    int         n;
    int         hi;
    int         fsn;
    int         urn;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[15];
  int   n_vec = 0;
  int   n_bad = 0;
  int   obs_hi, obs_fs, obs_ur;

  int         m_pre;
  logic [7:0] m_cnt, m_duty, m_hold;
  logic       m_full, m_en_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_duty = 0; m_hold = 0; m_full = 0; m_en_prev = 0;
  endtask

  // Predict post-edge outputs, queue them, then compare against the DUT after the edge.
  task automatic step(input string name);
    obs_t exp_o, act_o;
    logic tick, bnd, acc;
    tick = enable && (m_pre == P - 1);
    bnd  = tick && (m_cnt == 8'hFF);
    acc  = sample_valid && !m_full;
    exp_o.fs = bnd || (enable && !m_en_prev);
    exp_o.ur = bnd && !m_full;
    if (bnd && m_full) m_duty = m_hold;
    if (acc) begin
      m_hold = sample;
      m_full = 1'b1;
    end else if (bnd) begin
      m_full = 1'b0;
    end
    if (!enable) begin
      m_pre = 0; m_cnt = 0;
    end else if (tick) begin
      m_pre = 0; m_cnt = m_cnt + 8'd1;
    end else begin
      m_pre = m_pre + 1;
    end
    m_en_prev = enable;
    exp_o.rdy = !m_full;
    exp_o.pwm = enable && (m_cnt < m_duty);
    sb.push_back(exp_o);
    @(posedge clk);
    #1;
    act_o = {sample_ready, pwm_out, frame_start, underrun};
    exp_o = sb.pop_front();
    n_vec++;
    if (act_o !== exp_o) begin
      n_bad++;
      $display("FAIL %s cycle: rdy/pwm/fs/ur got %b expected %b", name, act_o, exp_o);
    end
    if (pwm_out === 1'b1) obs_hi++;
    if (frame_start === 1'b1) obs_fs++;
    if (underrun === 1'b1) obs_ur++;
  endtask

  task automatic run_vec(input vec_t v);
    enable = v.en; sample_valid = v.vld; sample = v.smp;
    obs_hi = 0; obs_fs = 0; obs_ur = 0;
    for (int i = 0; i < v.n; i++) step(v.name);
    check({v.name, "_high"}, obs_hi, v.hi);
    check({v.name, "_frame_start"}, obs_fs, v.fsn);
    check({v.name, "_underrun"}, obs_ur, v.urn);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, {31'd0, sample_ready}, 1);
    check({name, "_pwm"}, {31'd0, pwm_out}, 0);
    check({name, "_fs"}, {31'd0, frame_start}, 0);
    check({name, "_ur"}, {31'd0, underrun}, 0);
  endtask

  initial begin
    vec_t post;
    int hi3, fs3n, ur3n;
    // name, en, vld, sample, cycles, expected high / frame_start / underrun counts
    vecs[0]  = '{"no_sample",  1'b1, 1'b0, 8'h00, 512, 0,  3, 2};
    vecs[1]  = '{"accept_64",  1'b1, 1'b1, 8'd64, 1,   0,  0, 0};
    vecs[2]  = '{"fill_frame", 1'b1, 1'b0, 8'h00, 254, 0,  0, 0};
    vecs[3]  = '{"play_64",    1'b1, 1'b0, 8'h00, 256, 64, 1, 0};
    vecs[4]  = '{"repeat_64",  1'b1, 1'b0, 8'h00, 256, 64, 1, 1};
    vecs[5]  = '{"acc_at_bnd", 1'b1, 1'b1, 8'h10, 1,   1,  1, 1};
    vecs[6]  = '{"stall_20",   1'b1, 1'b1, 8'h20, 255, 63, 0, 0};
    vecs[7]  = '{"load_10",    1'b1, 1'b1, 8'h20, 2,   2,  1, 0};
    vecs[8]  = '{"play_10",    1'b1, 1'b0, 8'h00, 254, 14, 0, 0};
    vecs[9]  = '{"play_20",    1'b1, 1'b0, 8'h00, 256, 32, 1, 0};
    vecs[10] = '{"disable",    1'b0, 1'b0, 8'h00, 5,   0,  0, 0};
    vecs[11] = '{"acc_off",    1'b0, 1'b1, 8'h40, 1,   0,  0, 0};
    vecs[12] = '{"reenable",   1'b1, 1'b0, 8'h00, 256, 32, 2, 0};
    vecs[13] = '{"acc_80",     1'b1, 1'b1, 8'h80, 1,   1,  0, 0};
    vecs[14] = '{"pre_reset",  1'b1, 1'b0, 8'h00, 9,   9,  0, 0};

    #2 nRst = 1'b0;
    #1 check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_held");
    model_reset();
    nRst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Async reset mid-frame with a pending sample while pwm_out is high.
    check("pre_reset_pwm_high", {31'd0, pwm_out}, 1);
    check("pre_reset_hold_full", {31'd0, sample_ready}, 0);
    nRst = 1'b0;
    #1 check_reset_outputs("reset_midframe");
    enable = 1'b0; sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset_midframe_held");
    model_reset();
    nRst = 1'b1;
    post = '{"post_reset", 1'b1, 1'b0, 8'h00, 256, 0, 2, 1};
    run_vec(post);

    // PRESCALE=3: full-scale duty gives a 768-cycle frame high for 765 cycles.
    v3 = 1'b1; s3 = 8'hFF;
    @(posedge clk);
    #1 check("p3_accept", {31'd0, rdy3}, 0);
    v3 = 1'b0; en3 = 1'b1;
    hi3 = 0; fs3n = 0; ur3n = 0;
    for (int i = 0; i < 767; i++) begin
      @(posedge clk); #1;
      if (pwm3 === 1'b1) hi3++;
      if (fs3 === 1'b1) fs3n++;
      if (ur3 === 1'b1) ur3n++;
    end
    check("p3_first_high", hi3, 0);
    check("p3_first_fs", fs3n, 1);
    check("p3_first_ur", ur3n, 0);
    hi3 = 0; fs3n = 0; ur3n = 0;
    for (int i = 0; i < 768; i++) begin
      @(posedge clk); #1;
      if (pwm3 === 1'b1) hi3++;
      if (fs3 === 1'b1) fs3n++;
      if (ur3 === 1'b1) ur3n++;
    end
    check("p3_frame_high", hi3, 765);
    check("p3_frame_fs", fs3n, 1);
    check("p3_frame_ur", ur3n, 0);
    @(posedge clk);
    #1;
    check("p3_next_fs", {31'd0, fs3}, 1);
    check("p3_next_ur", {31'd0, ur3}, 1);
    check("p3_next_pwm", {31'd0, pwm3}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
- REQ-001: Parameter PRESCALE, default 1, is the number of clk cycles per PWM count step; legal range is 1..1023.
- REQ-002: clk  input  1  is the single system clock; all state updates on its rising edge.
- REQ-003: nRst  input  1  is the asynchronous, active-low reset.
- REQ-004: enable  input  1  runs PWM generation when high.
- REQ-005: sample  input  8  is the unsigned duty sample from the oscillator/mixer path.
- REQ-006: sample_valid  input  1  indicates that sample holds a new value.
- REQ-007: sample_ready  output  1  indicates that the holding register can accept a sample.
- REQ-008: pwm_out  output  1  is the 1-bit PWM audio output.
- REQ-009: frame_start  output  1  is a one-cycle pulse when a new PWM frame begins.
- REQ-010: underrun  output  1  is a one-cycle pulse when a frame begins with no pending sample.

Function
- REQ-011: The block SHALL contain the following registers:
  - a 10-bit prescaler counter, pre;
  - an 8-bit frame counter, cnt;
  - an 8-bit active duty register, duty;
  - an 8-bit holding register, hold, with a full flag, hold_full.
- REQ-012: sample_ready SHALL equal !hold_full, combinationally from the register.
- REQ-013: Accept occurs when sample_valid && sample_ready; on accept, hold<=sample and hold_full<=1.
- REQ-014: sample_valid while sample_ready=0 SHALL be ignored; hold is not overwritten.
- REQ-015: Accepts SHALL occur regardless of enable.
- REQ-016: tick SHALL be asserted when enable=1 and pre==PRESCALE-1.
  - On tick, pre<=0.
  - Else, when enable=1, pre<=pre+1.
- REQ-017: On tick, cnt<=cnt+1, wrapping modulo 256 (255->0); a frame is 256 ticks.
- REQ-018: A frame boundary is a tick with cnt==255.
- REQ-019: At a frame boundary with hold_full=1, duty<=hold and hold_full<=0 in the same cycle.
- REQ-020: At a frame boundary with hold_full=0:
  - duty SHALL be retained;
  - underrun SHALL pulse high for exactly one cycle.
- REQ-021: When an accept and a frame boundary occur in the same cycle (hold empty), the boundary SHALL take effect first:
  - underrun pulses;
  - duty is retained;
  - the new sample lands in hold and sets hold_full.
- REQ-022: frame_start SHALL pulse high for exactly one cycle, in the cycle following every frame boundary (cnt==0 after the tick).
- REQ-023: frame_start SHALL also pulse in the first cycle after enable rises.
- REQ-024: pwm_out SHALL equal enable && (cnt < duty), decoded from registered values only.
  - duty=0 gives a constant low output.
  - duty=255 gives an output high for 255 of 256 counts.
- REQ-025: When enable=0:
  - pre<=0 and cnt<=0;
  - pwm_out=0;
  - no tick, frame_start or underrun occurs;
  - duty and hold are retained.
- REQ-026: When enable rises, counting SHALL restart from cnt=0, pre=0; the first boundary occurs 256*PRESCALE cycles later.
- REQ-027: At PRESCALE=1 there is one count per clk; pwm_out high time per frame = duty clk cycles.

Reset
- REQ-028: While nRst=0, the block SHALL hold these values:
  - pre=0, cnt=0, duty=0, hold=0, hold_full=0;
  - sample_ready=1, pwm_out=0, frame_start=0, underrun=0.
- REQ-029: Reset SHALL take effect immediately, independent of clk, including mid-frame and mid-handshake; any pending sample is discarded.
- REQ-030: After nRst deasserts with enable=1, operation SHALL proceed as in REQ-026 from cnt=0.

Verification
- REQ-031: Reset, then PRESCALE=1, enable=1, no samples -> pwm_out stays 0; underrun pulses once every 256 cycles.
- REQ-032: Accept sample=64, then wait for the frame boundary -> next frame has pwm_out high exactly 64 cycles, low 192; frame_start pulses once per frame; sample_ready returns to 1 at the boundary.
- REQ-033: Present 0x10 then 0x20 with sample_valid held high -> 0x10 accepted; 0x20 stalls (ready=0) until the boundary, then is accepted; frames play 0x10 then 0x20.
- REQ-034: PRESCALE=3, duty=255 -> frame lasts 768 cycles; pwm_out high 765 cycles; boundary at pre==2, cnt==255.
- REQ-035: Mid-frame behaviour:
  - enable dropped mid-frame -> pwm_out=0 next cycle; cnt=0; duty and hold unchanged; re-enable -> frame_start pulses.
  - nRst asserted mid-frame with hold_full=1 -> all outputs at their reset values immediately.
- REQ-036: Accept coinciding with a boundary while hold is empty -> underrun pulses; duty unchanged; hold_full=1 next cycle.
